// File: rtl/bin_tape_loader_pkg.sv
// rtl/bin_tape_loader_pkg.sv - shared types and frame constants for the BIN tape loader
package bin_tape_loader_pkg;

    typedef logic [11:0] word;

    localparam logic [7:0] BIN_LEADER     = 8'o200;
    localparam int         BIN_ORIGIN_BIT = 6;
    localparam int         BIN_FIELD_BIT  = 7;

    localparam int PAGES          = 32;
    localparam int WORDS_PER_PAGE = 128;
    localparam int MEM_WORDS      = PAGES * WORDS_PER_PAGE;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEADER,
        ST_HIGH,
        ST_LOW,
        ST_COMMIT,
        ST_WAIT_MEM,
        ST_DONE,
        ST_ERROR
    } loader_state_t;

    typedef enum logic [1:0] {
        FR_LEADER,
        FR_FIELD,
        FR_ORIGIN,
        FR_DATA
    } frame_class_t;

    // Memory is one flat 4K-word field, so the top address wraps to zero.
    function automatic word next_address(input word addr);
        return (addr == word'(MEM_WORDS - 1)) ? '0 : addr + 12'd1;
    endfunction

    // BIN checksum sums whole frame bytes, including the origin flag bit.
    function automatic word add_frames(input word sum, input logic [7:0] hi, input logic [7:0] lo);
        return sum + {4'b0000, hi} + {4'b0000, lo};
    endfunction

endpackage

// File: rtl/bin_tape_loader_if.sv
// rtl/bin_tape_loader_if.sv - tape byte stream and memory write bus between source/memory and loader
interface bin_tape_loader_if;
    import bin_tape_loader_pkg::*;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    word        mem_address;
    word        mem_write_data;
    logic       mem_write_enable;
    logic       mem_finished;

    modport master (
        output rx_data, rx_valid, mem_finished,
        input  rx_ready, mem_address, mem_write_data, mem_write_enable
    );

    modport slave (
        input  rx_data, rx_valid, mem_finished,
        output rx_ready, mem_address, mem_write_data, mem_write_enable
    );

endinterface

// File: rtl/bin_tape_loader_frame_decoder.sv
// rtl/bin_tape_loader_frame_decoder.sv - combinational classifier for one BIN tape frame
module bin_tape_loader_frame_decoder
    import bin_tape_loader_pkg::*;
#(
    parameter logic [7:0] LEADER_BYTE = BIN_LEADER
) (
    input  logic [7:0]   frame,
    output frame_class_t frame_class,
    output logic         low_bad
);

    always_comb begin
        frame_class = FR_DATA;
        if (frame == LEADER_BYTE) begin
            frame_class = FR_LEADER;
        end else if (frame[BIN_FIELD_BIT]) begin
            frame_class = FR_FIELD;
        end else if (frame[BIN_ORIGIN_BIT]) begin
            frame_class = FR_ORIGIN;
        end
    end

    // A low half carries only six payload bits; any flag bit there means a torn tape.
    assign low_bad = frame[BIN_FIELD_BIT] | frame[BIN_ORIGIN_BIT];

endmodule

// File: rtl/bin_tape_loader.sv
// rtl/bin_tape_loader.sv - decodes a PDP-8 BIN tape stream and deposits words into memory
module bin_tape_loader
    import bin_tape_loader_pkg::*;
#(
    parameter logic [7:0] LEADER_BYTE = BIN_LEADER,
    parameter word        DEFAULT_PC  = 12'o200
) (
    input  logic               clk,
    input  logic               btnCpuReset,
    input  logic               load_start,
    bin_tape_loader_if.slave   bus,
    output logic               busy,
    output logic               done,
    output logic               checksum_error,
    output word                start_pc,
    output word                words_written
);

    loader_state_t state, state_next;
    frame_class_t  frame_class;
    logic          low_bad;
    logic          rx_ready_c;
    logic          accept;
    logic          is_word_frame;
    logic          trailer_ok;

    logic [7:0] hi_byte;
    logic [7:0] cur_hi, cur_lo;
    logic [7:0] pend_hi, pend_lo;
    logic       pend_valid;
    word        pend_value;
    word        sum;
    logic       origin_seen;

    word  mem_addr_q, mem_data_q;
    logic mem_we_q;

    bin_tape_loader_frame_decoder #(.LEADER_BYTE(LEADER_BYTE)) u_decoder (
        .frame       (bus.rx_data),
        .frame_class (frame_class),
        .low_bad     (low_bad)
    );

    assign is_word_frame = (frame_class == FR_ORIGIN) || (frame_class == FR_DATA);
    assign pend_value    = {pend_hi[5:0], pend_lo[5:0]};
    // The last pending word before the trailer is the checksum and is never written.
    assign trailer_ok    = pend_valid && !pend_hi[BIN_ORIGIN_BIT] && (pend_value == sum);
    assign accept        = bus.rx_valid && rx_ready_c;

    always_ff @(posedge clk or negedge btnCpuReset) begin
        if (!btnCpuReset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        rx_ready_c = 1'b0;
        busy       = 1'b1;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (load_start) state_next = ST_LEADER;
            end
            ST_LEADER: begin
                rx_ready_c = 1'b1;
                if (bus.rx_valid && is_word_frame) state_next = ST_LOW;
            end
            ST_HIGH: begin
                rx_ready_c = 1'b1;
                if (bus.rx_valid) begin
                    if (frame_class == FR_LEADER) begin
                        state_next = trailer_ok ? ST_DONE : ST_ERROR;
                    end else if (is_word_frame) begin
                        state_next = ST_LOW;
                    end
                end
            end
            ST_LOW: begin
                rx_ready_c = 1'b1;
                if (bus.rx_valid) begin
                    if (low_bad) begin
                        state_next = ST_ERROR;
                    end else if (pend_valid) begin
                        state_next = ST_COMMIT;
                    end else begin
                        state_next = ST_HIGH;
                    end
                end
            end
            ST_COMMIT: begin
                state_next = pend_hi[BIN_ORIGIN_BIT] ? ST_HIGH : ST_WAIT_MEM;
            end
            ST_WAIT_MEM: begin
                if (bus.mem_finished) state_next = ST_HIGH;
            end
            ST_DONE, ST_ERROR: begin
                busy       = 1'b0;
                state_next = ST_IDLE;
            end
            default: begin
                busy       = 1'b0;
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge btnCpuReset) begin
        if (!btnCpuReset) begin
            hi_byte        <= '0;
            cur_hi         <= '0;
            cur_lo         <= '0;
            pend_hi        <= '0;
            pend_lo        <= '0;
            pend_valid     <= 1'b0;
            sum            <= '0;
            origin_seen    <= 1'b0;
            mem_addr_q     <= '0;
            mem_data_q     <= '0;
            mem_we_q       <= 1'b0;
            done           <= 1'b0;
            checksum_error <= 1'b0;
            start_pc       <= DEFAULT_PC;
            words_written  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (load_start) begin
                        done           <= 1'b0;
                        checksum_error <= 1'b0;
                        words_written  <= '0;
                        sum            <= '0;
                        pend_valid     <= 1'b0;
                        origin_seen    <= 1'b0;
                        start_pc       <= DEFAULT_PC;
                    end
                end
                ST_LEADER, ST_HIGH: begin
                    if (accept && is_word_frame) hi_byte <= bus.rx_data;
                end
                ST_LOW: begin
                    if (accept && !low_bad) begin
                        if (pend_valid) begin
                            cur_hi <= hi_byte;
                            cur_lo <= bus.rx_data;
                        end else begin
                            pend_hi    <= hi_byte;
                            pend_lo    <= bus.rx_data;
                            pend_valid <= 1'b1;
                        end
                    end
                end
                ST_COMMIT: begin
                    sum <= add_frames(sum, pend_hi, pend_lo);
                    if (pend_hi[BIN_ORIGIN_BIT]) begin
                        mem_addr_q <= pend_value;
                        if (!origin_seen) begin
                            start_pc    <= pend_value;
                            origin_seen <= 1'b1;
                        end
                    end else begin
                        mem_data_q <= pend_value;
                        mem_we_q   <= 1'b1;
                    end
                    pend_hi <= cur_hi;
                    pend_lo <= cur_lo;
                end
                ST_WAIT_MEM: begin
                    if (bus.mem_finished) begin
                        mem_we_q      <= 1'b0;
                        mem_addr_q    <= next_address(mem_addr_q);
                        words_written <= words_written + 12'd1;
                    end
                end
                ST_DONE:  done           <= 1'b1;
                ST_ERROR: checksum_error <= 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.rx_ready         = rx_ready_c;
    assign bus.mem_address      = mem_addr_q;
    assign bus.mem_write_data   = mem_data_q;
    assign bus.mem_write_enable = mem_we_q;

endmodule
